// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM state encodings and default latencies for the E-stage mul/div unit
package md_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
endpackage

// File: rtl/e_md_if.sv
// e_md_if: operand/op bundle into the mul/div unit and busy/hi/lo back out
interface e_md_if;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output md_op, start, rs_val, rt_val, input busy, hi, lo);
  modport slave(input md_op, start, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/e_md_alu.sv
// e_md_alu: combinational 64-bit {hi,lo} result for mul/div ops; MD_MADD_EN adds MADD/MADDU accumulation
module e_md_alu
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        dz
);
  logic        msgn, dsgn, is_div, acc;
  logic [63:0] prod;
  logic [31:0] a, b, bd, q, r;
  assign msgn = op == MD_MULT || op == MD_MADD;
  assign dsgn = op == MD_DIV;
  assign is_div = op == MD_DIV || op == MD_DIVU;
`ifdef MD_MADD_EN
  assign acc = op == MD_MADD || op == MD_MADDU;
`else
  assign acc = 1'b0;
`endif
  assign prod = {{32{msgn & rs[31]}}, rs} * {{32{msgn & rt[31]}}, rt};
  // signed divide on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000)
  assign a  = dsgn && rs[31] ? -rs : rs;
  assign b  = dsgn && rt[31] ? -rt : rt;
  assign bd = b == 32'd0 ? 32'd1 : b;
  assign q  = a / bd;
  assign r  = a % bd;
  assign dz = rt == 32'd0;
  assign res = is_div ? {dsgn && rs[31] ? -r : r, dsgn && (rs[31] ^ rt[31]) ? -q : q}
             : acc ? {hi, lo} + prod : prod;
endmodule

// File: rtl/e_md.sv
// e_md: multi-cycle MULT/DIV unit with HI/LO registers and busy handshake; MD_MADD_EN enables MADD/MADDU
module e_md
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input logic clk,
  input logic reset,
  e_md_if.slave m
);
`ifdef MD_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [31:0] hi_q, lo_q;
  logic [63:0] res, res_q;
  logic        dz, dz_q, is_mul, is_div;
  e_md_alu u_alu (.op(m.md_op), .rs(m.rs_val), .rt(m.rt_val), .hi(hi_q), .lo(lo_q), .res(res), .dz(dz));
  assign is_mul = m.md_op == MD_MULT || m.md_op == MD_MULTU
               || (MADD_EN && (m.md_op == MD_MADD || m.md_op == MD_MADDU));
  assign is_div = m.md_op == MD_DIV || m.md_op == MD_DIVU;
  assign m.busy = state != S_IDLE;
  assign m.hi = hi_q;
  assign m.lo = lo_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
      dz_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (m.start && is_mul) begin
        res_q <= res;
        dz_q  <= 1'b0;
        cnt   <= 16'(MUL_CYCLES);
        state <= S_MUL;
      end else if (m.start && is_div) begin
        res_q <= res;
        dz_q  <= dz;
        cnt   <= 16'(DIV_CYCLES);
        state <= S_DIV;
      end else if (m.start && m.md_op == MD_MTHI) begin
        hi_q <= m.rs_val;
      end else if (m.start && m.md_op == MD_MTLO) begin
        lo_q <= m.rs_val;
      end
    end else begin
      // divide-by-zero still runs the full latency but leaves hi/lo untouched
      cnt <= cnt - 16'd1;
      if (cnt == 16'd1) begin
        state <= S_IDLE;
        if (!dz_q) {hi_q, lo_q} <= res_q;
      end
    end
  end
endmodule

// File: tb/tb_e_md.sv
// tb_e_md: directed self-checking bench for e_md (expectations follow MD_MADD_EN)
module tb_e_md;
  import md_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int n;
  e_md_if m();
  e_md u_dut (.clk(clk), .reset(reset), .m(m));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    m.md_op = op;
    m.rs_val = a;
    m.rt_val = b;
    m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.md_op = MD_NONE;
    m.rs_val = 32'h5a5a5a5a;
    m.rt_val = 32'ha5a5a5a5;
  endtask
  task automatic wait_idle(inout int cnt);
    while (m.busy && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    issue(op, a, b);
    n = 0;
    wait_idle(n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_hi"}, 64'(m.hi), 64'(ehi));
    check({tag, "_lo"}, 64'(m.lo), 64'(elo));
  endtask
  initial begin
    m.md_op = MD_NONE;
    m.start = 1'b0;
    m.rs_val = '0;
    m.rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(m.busy), 64'd0);
    check("rst_hi", 64'(m.hi), 64'd0);
    check("rst_lo", 64'(m.lo), 64'd0);
    reset = 1'b1;
    run("mult", MD_MULT, 32'hfffffffe, 32'd3, 5, 32'hffffffff, 32'hfffffffa);
    run("multu", MD_MULTU, 32'hfffffffe, 32'd3, 5, 32'h00000002, 32'hfffffffa);
    run("div", MD_DIV, 32'hfffffff9, 32'd2, 10, 32'hffffffff, 32'hfffffffd);
    run("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run("div_ovf", MD_DIV, 32'h80000000, 32'hffffffff, 10, 32'd0, 32'h80000000);
    run("mthi11", MD_MTHI, 32'h11, 32'd0, 0, 32'h11, 32'h80000000);
    run("mtlo22", MD_MTLO, 32'h22, 32'd0, 0, 32'h11, 32'h22);
    run("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run("mthi", MD_MTHI, 32'hdeadbeef, 32'd0, 0, 32'hdeadbeef, 32'h22);
    issue(MD_MULT, 32'd6, 32'd7);
    m.md_op = MD_MULT;
    m.rs_val = 32'd100;
    m.rt_val = 32'd100;
    m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.md_op = MD_NONE;
    n = 1;
    wait_idle(n);
    check("busy_ign_lat", 64'(n), 64'd5);
    check("busy_ign_res", {m.hi, m.lo}, 64'd42);
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (6) @(posedge clk);
    #1;
    check("mid_div_busy", 64'(m.busy), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("mid_rst_busy", 64'(m.busy), 64'd0);
    check("mid_rst_hilo", {m.hi, m.lo}, 64'd0);
    run("post_rst", MD_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    run("pre_hi", MD_MTHI, 32'd0, 32'd0, 0, 32'd0, 32'd12);
    run("pre_lo", MD_MTLO, 32'hffffffff, 32'd0, 0, 32'd0, 32'hffffffff);
`ifdef MD_MADD_EN
    run("maddu", MD_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run("madd", MD_MADD, 32'hffffffff, 32'd1, 5, 32'd0, 32'hffffffff);
`else
    run("maddu", MD_MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hffffffff);
    run("madd", MD_MADD, 32'hffffffff, 32'd1, 0, 32'd0, 32'hffffffff);
`endif
    run("badop", 4'd15, 32'd9, 32'd9, 0, 32'd0, 32'hffffffff);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
